// File: rtl/riscv_constants.sv
// Constants shared by the RISC-V memory datapath: access-size codes and requester ids.
package riscv_constants;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/pipeline.sv
// Generic fixed-depth register pipeline with synchronous clear.
module pipeline #(
  parameter int unsigned PIPELINE_STAGES = 1,
  parameter int unsigned PIPELINE_WIDTH  = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [PIPELINE_WIDTH-1:0] data_in,
  output logic [PIPELINE_WIDTH-1:0] data_out
);

  logic [PIPELINE_WIDTH-1:0] stages [PIPELINE_STAGES];

  // Shift data one stage per cycle; reset clears every stage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < PIPELINE_STAGES; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= data_in;
      for (int unsigned i = 1; i < PIPELINE_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign data_out = stages[PIPELINE_STAGES-1];

endmodule

// File: rtl/riscv_memory_arbiter.sv
// Arbitrates the CPU memory port between instruction fetch and load/store,
// and routes fixed-latency read data back to the issuing requester.
module riscv_memory_arbiter
  import riscv_constants::*;
#(
  parameter int unsigned READ_LATENCY    = 2,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        i_valid_in,
  input  logic [31:0] i_addr_in,
  output logic        i_ready_out,
  output logic        i_resp_valid_out,
  output logic [31:0] i_resp_data_out,
  input  logic        d_valid_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_data_in,
  input  logic [2:0]  d_size_in,
  input  logic        d_write_in,
  output logic        d_ready_out,
  output logic        d_resp_valid_out,
  output logic [31:0] d_resp_data_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [2:0]  mem_size_out,
  output logic        mem_write_enable_out,
  output logic        mem_read_enable_out,
  input  logic [31:0] mem_data_in
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_next;
  logic                forced_fetch;
  logic                grant_i;
  logic                grant_d;
  logic                grant_read;
  req_id_t             grant_id;
  logic [1:0]          track_in;
  logic [1:0]          track_out;
  logic                tail_valid;
  req_id_t             tail_id;

  // Grant data first unless fetch has waited through a full data streak.
  always_comb begin
    forced_fetch = i_valid_in && (streak == STREAK_MAX);
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    if (!rst_in) begin
      if (d_valid_in && !forced_fetch) begin
        grant_d = 1'b1;
      end else if (i_valid_in) begin
        grant_i = 1'b1;
      end
    end
  end

  assign i_ready_out = grant_i;
  assign d_ready_out = grant_d;

  // Drive the memory port from whichever requester won; idle port is all zero.
  always_comb begin
    mem_addr_out         = '0;
    mem_data_out         = '0;
    mem_size_out         = '0;
    mem_write_enable_out = 1'b0;
    mem_read_enable_out  = 1'b0;
    if (grant_d) begin
      mem_addr_out         = d_addr_in;
      mem_data_out         = d_data_in;
      mem_size_out         = d_size_in;
      mem_write_enable_out = d_write_in;
      mem_read_enable_out  = !d_write_in;
    end else if (grant_i) begin
      mem_addr_out        = i_addr_in;
      mem_size_out        = MASK_W;
      mem_read_enable_out = 1'b1;
    end
  end

  // Count data grants that happen while fetch is waiting; saturate at the limit.
  always_comb begin
    streak_next = streak;
    if (!i_valid_in || grant_i) begin
      streak_next = '0;
    end else if (grant_d && (streak != STREAK_MAX)) begin
      streak_next = streak + 1'b1;
    end
  end

  // Streak register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      streak <= '0;
    end else begin
      streak <= streak_next;
    end
  end

  // Tag each cycle with {read issued, requester} for the latency tracker.
  always_comb begin
    grant_read = grant_i || (grant_d && !d_write_in);
    grant_id   = grant_d ? REQ_DATA : REQ_FETCH;
    track_in   = {grant_read, grant_id};
  end

  pipeline #(
    .PIPELINE_STAGES(READ_LATENCY),
    .PIPELINE_WIDTH (2)
  ) u_tracker (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .data_in (track_in),
    .data_out(track_out)
  );

  // Steer returning read data to the requester recorded at the tracker tail.
  always_comb begin
    tail_valid       = track_out[1] && !rst_in;
    tail_id          = req_id_t'(track_out[0]);
    i_resp_valid_out = 1'b0;
    i_resp_data_out  = '0;
    d_resp_valid_out = 1'b0;
    d_resp_data_out  = '0;
    if (tail_valid) begin
      if (tail_id == REQ_DATA) begin
        d_resp_valid_out = 1'b1;
        d_resp_data_out  = mem_data_in;
      end else begin
        i_resp_valid_out = 1'b1;
        i_resp_data_out  = mem_data_in;
      end
    end
  end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Randomized scoreboard bench for riscv_memory_arbiter.
module tb_riscv_memory_arbiter;
  import riscv_constants::*;

  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        i_valid_in;
  logic [31:0] i_addr_in;
  logic        i_ready_out;
  logic        i_resp_valid_out;
  logic [31:0] i_resp_data_out;
  logic        d_valid_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_data_in;
  logic [2:0]  d_size_in;
  logic        d_write_in;
  logic        d_ready_out;
  logic        d_resp_valid_out;
  logic [31:0] d_resp_data_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [2:0]  mem_size_out;
  logic        mem_write_enable_out;
  logic        mem_read_enable_out;
  logic [31:0] mem_data_in;

  always #5 clk = ~clk;

  riscv_memory_arbiter #(
    .READ_LATENCY   (LAT),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst_in),
    .i_valid_in          (i_valid_in),
    .i_addr_in           (i_addr_in),
    .i_ready_out         (i_ready_out),
    .i_resp_valid_out    (i_resp_valid_out),
    .i_resp_data_out     (i_resp_data_out),
    .d_valid_in          (d_valid_in),
    .d_addr_in           (d_addr_in),
    .d_data_in           (d_data_in),
    .d_size_in           (d_size_in),
    .d_write_in          (d_write_in),
    .d_ready_out         (d_ready_out),
    .d_resp_valid_out    (d_resp_valid_out),
    .d_resp_data_out     (d_resp_data_out),
    .mem_addr_out        (mem_addr_out),
    .mem_data_out        (mem_data_out),
    .mem_size_out        (mem_size_out),
    .mem_write_enable_out(mem_write_enable_out),
    .mem_read_enable_out (mem_read_enable_out),
    .mem_data_in         (mem_data_in)
  );

  typedef struct {
    int          due;
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0300: return 32'h1234_5678;
      default:       return a ^ {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
    endcase
  endfunction

  function automatic logic [31:0] read_result(input logic [31:0] a, input logic [2:0] s);
    logic mis;
    case (s)
      MASK_H, MASK_HU: mis = a[0];
      MASK_W:          mis = (a[1:0] != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis ? 32'h0 : mem_word({a[31:2], 2'b00});
  endfunction

  // Memory interface stand-in: read data appears LAT cycles after the read enable.
  logic [32:0] mpipe0 = '0;
  logic [32:0] mpipe1 = '0;
  always @(posedge clk) begin
    mpipe0 <= {mem_read_enable_out, read_result(mem_addr_out, mem_size_out)};
    mpipe1 <= mpipe0;
  end
  assign mem_data_in = mpipe1[32] ? mpipe1[31:0] : (32'hBAD0_0000 ^ cyc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester state and arbitration reference.
  logic        i_pend = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_pend = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_data = '0;
  logic [2:0]  d_size = MASK_W;
  logic        d_wr   = 1'b0;
  int          data_run = 0;
  int          last_grant = 0;

  task automatic req_fetch(input logic [31:0] a);
    i_pend = 1'b1;
    i_addr = a;
  endtask

  task automatic req_data(input logic [31:0] a, input logic [2:0] s, input logic wr,
                          input logic [31:0] dat);
    d_pend = 1'b1;
    d_addr = a;
    d_size = s;
    d_wr   = wr;
    d_data = dat;
  endtask

  // One bus cycle: drive held requests, predict the grant, compare, then advance.
  task automatic run_cycle();
    int          g;
    logic [31:0] e_addr, e_data;
    logic [2:0]  e_size;
    logic        e_we, e_re;
    i_valid_in = i_pend;
    i_addr_in  = i_pend ? i_addr : $urandom;
    d_valid_in = d_pend;
    d_addr_in  = d_pend ? d_addr : $urandom;
    d_data_in  = d_pend ? d_data : $urandom;
    d_size_in  = d_pend ? d_size : 3'($urandom);
    d_write_in = d_pend ? d_wr : 1'($urandom);
    @(negedge clk);
    if (rst_in) g = 0;
    else if (d_pend && !(i_pend && data_run >= MAXS)) g = 2;
    else if (i_pend) g = 1;
    else g = 0;
    e_addr = '0; e_data = '0; e_size = '0; e_we = 1'b0; e_re = 1'b0;
    if (g == 1) begin
      e_addr = i_addr; e_size = MASK_W; e_re = 1'b1;
    end else if (g == 2) begin
      e_addr = d_addr; e_data = d_data; e_size = d_size; e_we = d_wr; e_re = !d_wr;
    end
    check("i_ready", i_ready_out, (g == 1));
    check("d_ready", d_ready_out, (g == 2));
    check("mem_addr", mem_addr_out, e_addr);
    check("mem_data", mem_data_out, e_data);
    check("mem_size", mem_size_out, e_size);
    check("mem_we", mem_write_enable_out, e_we);
    check("mem_re", mem_read_enable_out, e_re);
    last_grant = d_ready_out ? 2 : (i_ready_out ? 1 : 0);
    if (g == 1) exp_q.push_back('{cyc + LAT, 1'b0, read_result(i_addr, MASK_W)});
    if (g == 2 && !d_wr) exp_q.push_back('{cyc + LAT, 1'b1, read_result(d_addr, d_size)});
    if (rst_in || !i_pend || g == 1) data_run = 0;
    else if (g == 2 && data_run < MAXS) data_run = data_run + 1;
    if (g == 1) i_pend = 1'b0;
    if (g == 2) d_pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every returned word must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    check("resp_both_valid", i_resp_valid_out & d_resp_valid_out, 1'b0);
    if (rst_in) begin
      check("rst_i_resp_valid", i_resp_valid_out, 1'b0);
      check("rst_d_resp_valid", d_resp_valid_out, 1'b0);
      exp_q.delete();
    end else if (i_resp_valid_out || d_resp_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", i_resp_valid_out | d_resp_valid_out, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("resp_cycle", cyc, e.due);
        check("resp_to_data", d_resp_valid_out, e.is_data);
        check("resp_to_fetch", i_resp_valid_out, !e.is_data);
        check("resp_data", e.is_data ? d_resp_data_out : i_resp_data_out, e.data);
        check("resp_other_zero", e.is_data ? i_resp_data_out : d_resp_data_out, 32'h0);
      end
    end else begin
      check("idle_i_resp_data", i_resp_data_out, 32'h0);
      check("idle_d_resp_data", d_resp_data_out, 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("resp_valid_when_due", i_resp_valid_out | d_resp_valid_out, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    string       hist;
    logic [2:0]  sizes [5];
    logic [31:0] a;
    sizes = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
    rst_in = 1'b1;
    i_valid_in = 1'b0; i_addr_in = '0;
    d_valid_in = 1'b0; d_addr_in = '0; d_data_in = '0; d_size_in = '0; d_write_in = 1'b0;
    @(posedge clk);
    #1;
    // Reset with requests pending: no grants, memory port idle.
    req_fetch(32'h0000_0040);
    req_data(32'h0000_0080, MASK_W, 1'b0, 32'h0);
    repeat (3) run_cycle();
    i_pend = 1'b0; d_pend = 1'b0;
    rst_in = 1'b0;
    repeat (2) run_cycle();

    // Fetch only.
    req_fetch(32'h0000_0100);
    repeat (4) run_cycle();

    // Simultaneous fetch and load.
    req_fetch(32'h0000_0200);
    req_data(32'h0000_0300, MASK_W, 1'b0, 32'h0);
    repeat (5) run_cycle();

    // Starvation bound with both requesters continuously valid.
    hist = "";
    for (int k = 0; k < 10; k++) begin
      if (!i_pend) req_fetch(32'h0000_1000 + 32'(k * 4));
      if (!d_pend) req_data(32'h0000_2000 + 32'(k * 4), MASK_W, 1'b0, 32'h0);
      run_cycle();
      hist = {hist, (last_grant == 2) ? "D" : (last_grant == 1) ? "I" : "-"};
    end
    n_cmp++;
    if (hist != "DDDDIDDDDI") begin
      n_err++;
      $display("FAIL grant_order: got %s expected DDDDIDDDDI", hist);
    end
    repeat (4) run_cycle();

    // Misaligned halfword store: completes at grant, no response.
    req_data(32'h0000_0402, MASK_H, 1'b1, 32'h0000_ABCD);
    repeat (5) run_cycle();

    // Reset while a load is in flight.
    req_data(32'h0000_0300, MASK_W, 1'b0, 32'h0);
    run_cycle();
    rst_in = 1'b1;
    req_fetch(32'h0000_0500);
    req_data(32'h0000_0600, MASK_W, 1'b0, 32'h0);
    run_cycle();
    rst_in = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    repeat (3) run_cycle();

    // Idle.
    repeat (4) run_cycle();

    // Random traffic with occasional reset.
    for (int k = 0; k < 600; k++) begin
      if (!i_pend && $urandom_range(0, 99) < 55) begin
        a = $urandom & 32'h0000_FFFC;
        if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
        req_fetch(a);
      end
      if (!d_pend && $urandom_range(0, 99) < 60) begin
        req_data($urandom & 32'h0000_FFFF, sizes[$urandom_range(0, 4)],
                 1'($urandom_range(0, 2) == 0), $urandom);
      end
      rst_in = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    rst_in = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    repeat (6) run_cycle();
    check("queue_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
